// File: rtl/lut_logic_bank.sv
// ============================================================================
// Module   : lut_logic_bank
// Brief    : Registered bank of three LUT logic functions (and2, and4, eq).
//            Optional macro LUT_CFG_EN enables run-time truth-table writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_logic_bank #(
  parameter logic [3:0]  AND2_INIT = 4'h8,
  parameter logic [15:0] AND4_INIT = 16'h8000,
  parameter logic [15:0] EQ_INIT   = 16'hDAA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  and2_addr,
  input  logic [3:0]  and4_addr,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [15:0] cfg_data,
  output logic        out_valid,
  output logic        and2_result,
  output logic        and4_result,
  output logic        eq_result
);

  localparam logic [1:0] SEL_AND2 = 2'd0;
  localparam logic [1:0] SEL_AND4 = 2'd1;
  localparam logic [1:0] SEL_EQ   = 2'd2;

  logic [3:0]  and2_tbl;
  logic [15:0] and4_tbl;
  logic [15:0] eq_tbl;
  logic [3:0]  eq_addr;

  assign eq_addr = {d, c, b, a};

`ifdef LUT_CFG_EN
  logic [3:0]  and2_tbl_q;
  logic [15:0] and4_tbl_q;
  logic [15:0] eq_tbl_q;

  // A write lands on the edge, so a lookup at that same edge still sees the old table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      and2_tbl_q <= AND2_INIT;
      and4_tbl_q <= AND4_INIT;
      eq_tbl_q   <= EQ_INIT;
    end else if (cfg_we) begin
      case (cfg_sel)
        SEL_AND2: and2_tbl_q <= cfg_data[3:0];
        SEL_AND4: and4_tbl_q <= cfg_data;
        SEL_EQ:   eq_tbl_q   <= cfg_data;
        default:  ;
      endcase
    end
  end

  assign and2_tbl = and2_tbl_q;
  assign and4_tbl = and4_tbl_q;
  assign eq_tbl   = eq_tbl_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^{cfg_we, cfg_sel, cfg_data, SEL_AND2, SEL_AND4, SEL_EQ};
  assign and2_tbl   = AND2_INIT;
  assign and4_tbl   = AND4_INIT;
  assign eq_tbl     = EQ_INIT;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      and2_result <= 1'b0;
      and4_result <= 1'b0;
      eq_result   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        and2_result <= and2_tbl[and2_addr];
        and4_result <= and4_tbl[and4_addr];
        eq_result   <= eq_tbl[eq_addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lut_logic_bank.sv
// ============================================================================
// Module   : tb_lut_logic_bank
// Brief    : Directed self-checking bench for lut_logic_bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut_logic_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  and2_addr;
  logic [3:0]  and4_addr;
  logic        a, b, c, d;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        out_valid;
  logic        and2_result;
  logic        and4_result;
  logic        eq_result;

  int checks = 0;
  int errors = 0;

  lut_logic_bank dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .and2_addr  (and2_addr),
    .and4_addr  (and4_addr),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .out_valid  (out_valid),
    .and2_result(and2_result),
    .and4_result(and4_result),
    .eq_result  (eq_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic eq_model(input logic [3:0] v);
    logic va, vb, vc, vd;
    {vd, vc, vb, va} = v;
    return ~(((va & vb & vc & vd) | (vc ^ va)) ^ vd);
  endfunction

  task automatic lookup_all_ones;
    in_valid = 1'b1; and2_addr = 2'd3; and4_addr = 4'd15; {d, c, b, a} = 4'b1111;
    tick();
    check("ones_valid", out_valid, 1'b1);
    check("ones_and2", and2_result, 1'b1);
    check("ones_and4", and4_result, 1'b1);
    check("ones_eq", eq_result, 1'b1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; and2_addr = '0; and4_addr = '0;
    {d, c, b, a} = 4'b0000; cfg_we = 1'b0; cfg_sel = 2'd3; cfg_data = '0;

    // Power-on reset
    #2 rst = 1'b1;
    #1;
    check("por_valid", out_valid, 1'b0);
    check("por_results", {and2_result, and4_result, eq_result}, 3'b000);
    tick(); tick();
    @(negedge clk) rst = 1'b0;
    lookup_all_ones();

    // and2 sweep
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; and2_addr = 2'(i);
      tick();
      check($sformatf("and2_%0d", i), and2_result, (i == 3) ? 1'b1 : 1'b0);
      check($sformatf("and2_vld_%0d", i), out_valid, 1'b1);
    end

    // and4 sweep
    for (int i = 0; i < 16; i++) begin
      and4_addr = 4'(i);
      tick();
      check($sformatf("and4_%0d", i), and4_result, (i == 15) ? 1'b1 : 1'b0);
    end

    // Equation sweep against the Boolean formula
    for (int i = 0; i < 16; i++) begin
      {d, c, b, a} = 4'(i);
      tick();
      check($sformatf("eq_%0d", i), eq_result, eq_model(4'(i)));
    end
    // Spot values computed by hand
    {d, c, b, a} = 4'b1101;
    tick();
    check("eq_1101", eq_result, 1'b0);
    {d, c, b, a} = 4'b1001;
    tick();
    check("eq_1001", eq_result, 1'b1);

    // Hold: results keep their last values while in_valid is low
    lookup_all_ones();
    in_valid = 1'b0; and2_addr = 2'd0; and4_addr = 4'd0; {d, c, b, a} = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_vld_%0d", i), out_valid, 1'b0);
      check($sformatf("hold_res_%0d", i), {and2_result, and4_result, eq_result}, 3'b111);
    end

    // cfg_sel=3 write changes nothing
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 16'hFFFF;
    tick();
    cfg_we = 1'b0;
    in_valid = 1'b1; and2_addr = 2'd0; and4_addr = 4'd0; {d, c, b, a} = 4'b0001;
    tick();
    check("noop_and2", and2_result, 1'b0);
    check("noop_and4", and4_result, 1'b0);
    check("noop_eq", eq_result, 1'b0);

`ifdef LUT_CFG_EN
    // Write OR table to and2 alongside a lookup of address 1
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 16'h000E;
    in_valid = 1'b1; and2_addr = 2'd1; and4_addr = 4'd15; {d, c, b, a} = 4'b0000;
    tick();
    cfg_we = 1'b0;
    check("cfg_same_edge", and2_result, 1'b0);
    tick();
    check("cfg_next_edge", and2_result, 1'b1);
    check("cfg_and4_kept", and4_result, 1'b1);
    check("cfg_eq_kept", eq_result, 1'b1);
    and2_addr = 2'd0;
    tick();
    check("cfg_or_0", and2_result, 1'b0);
    // Rewrite eq table to all-zeros and confirm
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 16'h0000;
    tick();
    cfg_we = 1'b0;
    tick();
    check("cfg_eq_new", eq_result, 1'b0);
`else
    // Writes are ignored when the configuration path is absent
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 16'h000E;
    in_valid = 1'b1; and2_addr = 2'd1;
    tick();
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 16'h0000;
    tick();
    cfg_we = 1'b0; {d, c, b, a} = 4'b0000;
    tick();
    check("nocfg_and2", and2_result, 1'b0);
    check("nocfg_eq", eq_result, 1'b1);
`endif

    // Mid-cycle reset clears outputs immediately and restores INIT tables
    lookup_all_ones();
    #3 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_results", {and2_result, and4_result, eq_result}, 3'b000);
    @(negedge clk) rst = 1'b0;
    in_valid = 1'b1; and2_addr = 2'd1; {d, c, b, a} = 4'b0000;
    tick();
    check("rst_and2_init", and2_result, 1'b0);
    check("rst_eq_init", eq_result, 1'b1);
    lookup_all_ones();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lut_logic_bank.md
Name: lut_logic_bank

Overview:
- Registered bank of three small lookup-table logic functions sharing one clock domain.
  - 2-input AND.
  - 4-input AND.
  - 4-input equation f = ((a&b&c&d)|(c^a)) XNOR d.
- Each function is a truth table indexed by its inputs.
- Sits in glue-logic paths where fixed Boolean functions must be retargetable without re-synthesis.
- Results leave through a 1-cycle output register with a valid flag.

Parameters:
- AND2_INIT, 4'h8, reset truth table of the 2-input LUT; bit i = result for address i.
- AND4_INIT, 16'h8000, reset truth table of the 4-input AND LUT.
- EQ_INIT, 16'hDAA5, reset truth table of the equation LUT; index = {d,c,b,a}.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  lookup request; inputs below are sampled when high
- and2_addr  input  2  2-input LUT address, bit0 = first operand
- and4_addr  input  4  4-input LUT address, bit0 = first operand
- a  input  1  equation operand a (index bit 0)
- b  input  1  equation operand b (index bit 1)
- c  input  1  equation operand c (index bit 2)
- d  input  1  equation operand d (index bit 3)
- cfg_we  input  1  truth-table write strobe
- cfg_sel  input  2  table select: 0 = and2, 1 = and4, 2 = eq, 3 = none
- cfg_data  input  16  new truth table; and2 uses bits [3:0]
- out_valid  output  1  registered results valid
- and2_result  output  1  registered and2 LUT output
- and4_result  output  1  registered and4 LUT output
- eq_result  output  1  registered equation LUT output

Behaviour:
- Reset (async, rst=1):
  - Tables load AND2_INIT, AND4_INIT and EQ_INIT.
  - out_valid and all three results go to 0 immediately and are held while rst=1.
- Lookup:
  - On a clk rising edge with in_valid=1, each result register loads table[address]; out_valid=1.
  - Latency is exactly 1 cycle; a new lookup is accepted every cycle, with no backpressure.
- in_valid=0 at the edge: out_valid goes to 0 and the result registers hold their previous values.
- Default contents:
  - and2 yields 1 only at address 3.
  - and4 yields 1 only at address 15.
  - eq yields ((a&b&c&d)|(c^a)) XNOR d for all 16 combinations.
- Configuration write:
  - On an edge with cfg_we=1, the selected table is replaced by cfg_data (and2 takes the low 4 bits).
  - cfg_sel=3 is a no-op.
  - Other tables are unaffected.
- A write and a lookup at the same edge: the lookup uses the pre-write contents; the new table applies from the next edge.
- Reset asserted mid-operation discards any in-flight result and any pending write, and restores the INIT tables.
- X/Z on any address while in_valid=1: the output content is not specified. out_valid still asserts.

Optional Feature:
- Macro LUT_CFG_EN.
- Defined: the cfg_we / cfg_sel / cfg_data write path is implemented as described above.
- Undefined:
  - Tables are constants equal to the INIT parameters.
  - The cfg ports remain on the interface but are ignored.
  - No table storage registers are synthesized.

Test Plan:
- Reset check: assert rst mid-cycle -> out_valid=0 and all results 0 without waiting for a clock edge; release rst; and2_addr=3, and4_addr=15, {d,c,b,a}=4'b1111 with in_valid=1 -> next cycle and2_result=1, and4_result=1, eq_result=1, out_valid=1.
- and2 sweep: drive and2_addr 0..3 on consecutive cycles -> results 0,0,0,1, each one cycle later; out_valid=1 throughout.
- and4 sweep: drive and4_addr 0..15 -> and4_result is 1 only for address 15.
- Equation sweep: drive {d,c,b,a} 0..15 -> eq_result matches the formula for every combination, e.g. 0000->1, 0001->0, 1001->1, 1101->0, 1111->1.
- Configuration write (LUT_CFG_EN defined): write cfg_sel=0, cfg_data=16'h000E (OR function) in the same cycle as a lookup of address 1 -> that result is 0; repeat the lookup next cycle -> 1; and4 and eq tables unchanged.
- Hold and no-op: in_valid=0 for 3 cycles -> out_valid=0 and results hold their last values; cfg_sel=3 write -> no table changes. With LUT_CFG_EN undefined, a cfg write leaves the default outputs unchanged.
